dpi_pkt_sequencer: RTL
======================

DPI_PKT_SEQUENCER -- requirements
Module: dpi_pkt_sequencer

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 64: flow-table entries; stream_id width is log2(NUM_STREAMS), 6 at default.
REQ-002 SHALL have parameter EOP_DRAIN, default 2: cycles from the last char_in_vld to the eop pulse, covering matcher latency.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port pkt_data, input, 32: packet word; byte [31:24] is first on the wire.
REQ-006 SHALL have port pkt_vld, input, 1: pkt_data, pkt_sop, pkt_eop, pkt_nbytes and flow_key are valid.
REQ-007 SHALL have port pkt_sop, input, 1: first word of a packet.
REQ-008 SHALL have port pkt_eop, input, 1: last word of a packet.
REQ-009 SHALL have port pkt_nbytes, input, 2: valid bytes in an eop word; 0 encodes 4.
REQ-010 SHALL have port flow_key, input, 32: flow hash, sampled only with sop.
REQ-011 SHALL have port pkt_rdy, output, 1: word accepted when pkt_vld and pkt_rdy are both high.
REQ-012 SHALL have port load_state, output, 1: one-cycle pulse telling matchers to restore state.
REQ-013 SHALL have port new_stream_id, output, 1: qualifies load_state; the flow was newly allocated.
REQ-014 SHALL have port stream_id, output, 6: stream of the current packet; held from load_state through eop.
REQ-015 SHALL have port char_in, output, 8: byte to the matchers.
REQ-016 SHALL have port char_in_vld, output, 1: char_in is valid.
REQ-017 SHALL have port eop, output, 1: one-cycle packet-finalize pulse.
REQ-018 SHALL have port proto_err, output, 1: one-cycle pulse on an input framing violation.

Function
REQ-019 FSM SHALL have states IDLE, LOOKUP, LOAD, GAP, BYTES, DRAIN.
REQ-020 IDLE: pkt_rdy=0, and SHALL go to LOOKUP when pkt_vld&pkt_sop, registering flow_key; the word is not consumed.
REQ-021 LOOKUP: SHALL compare the key against all valid table entries in one cycle; on hit, stream_id=index, new_stream_id=0.
REQ-022 LOOKUP miss: SHALL write the key at alloc_ptr, set it valid, set stream_id=alloc_ptr and new_stream_id=1, and increment alloc_ptr modulo NUM_STREAMS; a full table overwrites the oldest allocation.
REQ-023 LOAD: load_state=1 for exactly one cycle; new_stream_id is valid only in this cycle.
REQ-024 GAP: one idle cycle so matcher state_in is applied before the first byte.
REQ-025 BYTES: SHALL emit one byte per cycle with char_in_vld=1, in order [31:24], [23:16], [15:8], [7:0], with no bubbles while pkt_vld is high.
REQ-026 pkt_rdy SHALL be high only in the cycle the last byte of the current word is emitted: byte 3, or byte pkt_nbytes-1 on an eop word.
REQ-027 If pkt_vld is low at a word boundary, BYTES SHALL stall with char_in_vld=0 and keep its byte index.
REQ-028 After the last byte of an eop word, SHALL enter DRAIN and pulse eop exactly EOP_DRAIN cycles after that last char_in_vld, then return to IDLE.
REQ-029 An sop&eop single-word packet SHALL follow the full sequence LOOKUP→LOAD→GAP→BYTES→DRAIN.
REQ-030 pkt_vld without pkt_sop in IDLE SHALL pulse proto_err; the word is consumed for one cycle with pkt_rdy=1 and dropped.
REQ-031 pkt_sop on a mid-packet word SHALL pulse proto_err, and that word SHALL be processed as continuation data.
REQ-032 Outside BYTES, char_in_vld=0; outside DRAIN end, eop=0.

Reset
REQ-033 rst SHALL force IDLE, clear all table valid bits, and set alloc_ptr=0, byte index=0, stream_id=0.
REQ-034 rst SHALL force all outputs to 0 immediately, including mid-packet; no eop is emitted for an aborted packet.

Structure
REQ-035 SHALL put the FSM state enum, NUM_STREAMS default and pkt_nbytes encoding in shared package dpi_pkg.
REQ-036 SHALL place the flow table with lookup and allocation in sub-module dpi_flow_table.

Verification
REQ-037 Key 0xA5A5_0001, 5-byte packet 0x11223344 then 0x55 with nbytes=1: load_state with new_stream_id=1, id=0; chars 11,22,33,44,55; eop 2 cycles after 0x55.
REQ-038 Same key again: load_state with new_stream_id=0 and id=0.
REQ-039 65 distinct keys, then the first key again: the 65th gets id 0 and the first key is re-allocated new at id 1.
REQ-040 pkt_vld dropped for 3 cycles between words: char_in_vld gap of 3 cycles, byte order intact.
REQ-041 Non-sop word in IDLE: proto_err=1 for one cycle, no load_state; assert rst in BYTES: all outputs 0 and no eop.

Source files
------------

// File: rtl/dpi_pkg.sv
// dpi_pkg: shared types and constants for the DPI packet sequencer.
//   - state_t        : sequencer FSM states
//   - NUM_STREAMS_DEF: default flow-table depth
//   - EOP_DRAIN_DEF  : default eop delay after the last byte
//   - NBYTES_FULL    : pkt_nbytes code meaning all four bytes are valid
//   - last_byte_idx(): index of the final byte to emit from a word
package dpi_pkg;

  localparam int unsigned NUM_STREAMS_DEF = 64;
  localparam int unsigned EOP_DRAIN_DEF   = 2;
  localparam logic [1:0]  NBYTES_FULL     = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    LOAD,
    GAP,
    BYTES,
    DRAIN
  } state_t;

  // A non-eop word always carries 4 bytes. On an eop word, nbytes-1 wraps
  // 0 to 3, which is exactly the "0 encodes 4" rule.
  function automatic logic [1:0] last_byte_idx(input logic eop, input logic [1:0] nbytes);
    return eop ? 2'(nbytes - 2'd1) : 2'd3;
  endfunction

endpackage

// File: rtl/dpi_flow_table.sv
// dpi_flow_table: fully associative flow-key table with round-robin allocation.
//   clk, rst  : clock, asynchronous active-high reset
//   key       : flow key to look up (compared against all valid entries)
//   alloc     : write key at alloc_ptr, mark it valid, advance alloc_ptr
//   hit       : key matches a valid entry
//   hit_idx   : index of the matching entry (lowest index on a hit)
//   alloc_ptr : entry the next allocation will use (oldest when the table is full)
module dpi_flow_table
  import dpi_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = NUM_STREAMS_DEF,
  parameter int unsigned ID_W        = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     key,
  input  logic            alloc,
  output logic            hit,
  output logic [ID_W-1:0] hit_idx,
  output logic [ID_W-1:0] alloc_ptr
);

  logic [NUM_STREAMS-1:0] valid;
  logic [31:0]            keys [NUM_STREAMS];

  // Single-cycle parallel compare; descending scan leaves the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (valid[i] && (keys[i] == key)) begin
        hit     = 1'b1;
        hit_idx = ID_W'(i);
      end
    end
  end

  // Valid bits and allocation pointer; wrapping overwrites the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= '0;
      alloc_ptr <= '0;
    end else if (alloc) begin
      valid[alloc_ptr] <= 1'b1;
      alloc_ptr        <= (alloc_ptr == ID_W'(NUM_STREAMS - 1)) ? '0 : alloc_ptr + ID_W'(1);
    end
  end

  // Key storage is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      keys[alloc_ptr] <= key;
    end
  end

endmodule

// File: rtl/dpi_pkt_sequencer.sv
// dpi_pkt_sequencer: serialises 32-bit packet words into a byte stream for the
// pattern matchers, resolving each packet's flow to a stream id first.
//   clk, rst       : clock, asynchronous active-high reset
//   pkt_data/vld/sop/eop/nbytes, flow_key : packet word input
//   pkt_rdy        : word accepted when pkt_vld & pkt_rdy
//   load_state     : one-cycle pulse, matchers restore stream state
//   new_stream_id  : with load_state, the flow was newly allocated
//   stream_id      : stream of the current packet, held through eop
//   char_in/_vld   : byte to the matchers, first byte is pkt_data[31:24]
//   eop            : packet-finalize pulse, EOP_DRAIN cycles after the last byte
//   proto_err      : pulse on an input framing violation
module dpi_pkt_sequencer
  import dpi_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = NUM_STREAMS_DEF,
  parameter int unsigned EOP_DRAIN   = EOP_DRAIN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pkt_data,
  input  logic        pkt_vld,
  input  logic        pkt_sop,
  input  logic        pkt_eop,
  input  logic [1:0]  pkt_nbytes,
  input  logic [31:0] flow_key,
  output logic        pkt_rdy,
  output logic        load_state,
  output logic        new_stream_id,
  output logic [((NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1)-1:0] stream_id,
  output logic [7:0]  char_in,
  output logic        char_in_vld,
  output logic        eop,
  output logic        proto_err
);

  localparam int unsigned ID_W    = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int unsigned DRAIN_W = (EOP_DRAIN > 1) ? $clog2(EOP_DRAIN) : 1;

  state_t              state;
  logic [31:0]         key_q;
  logic [1:0]          byte_idx;
  logic                first_word;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic                hit;
  logic [ID_W-1:0]     hit_idx;
  logic [ID_W-1:0]     alloc_ptr;
  logic                alloc;
  logic [1:0]          last_idx;
  logic                word_done;
  logic [7:0]          cur_byte;

  assign alloc     = (state == LOOKUP) && !hit;
  assign last_idx  = last_byte_idx(pkt_eop, pkt_nbytes);
  assign word_done = (state == BYTES) && pkt_vld && (byte_idx == last_idx);

  // Ready must describe the word on the bus this cycle so the next word can
  // follow without a bubble; a stray non-sop word in IDLE is swallowed.
  assign pkt_rdy = !rst && (word_done || ((state == IDLE) && pkt_vld && !pkt_sop));

  // Byte lane select, most significant byte first.
  always_comb begin
    cur_byte = pkt_data[31:24];
    case (byte_idx)
      2'd0: cur_byte = pkt_data[31:24];
      2'd1: cur_byte = pkt_data[23:16];
      2'd2: cur_byte = pkt_data[15:8];
      2'd3: cur_byte = pkt_data[7:0];
      default: cur_byte = pkt_data[31:24];
    endcase
  end

  dpi_flow_table #(
    .NUM_STREAMS (NUM_STREAMS),
    .ID_W        (ID_W)
  ) u_flow_table (
    .clk       (clk),
    .rst       (rst),
    .key       (key_q),
    .alloc     (alloc),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .alloc_ptr (alloc_ptr)
  );

  // Sequencer FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      key_q         <= '0;
      byte_idx      <= '0;
      first_word    <= 1'b0;
      drain_cnt     <= '0;
      stream_id     <= '0;
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      char_in       <= '0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      load_state    <= 1'b0;
      new_stream_id <= 1'b0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      proto_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_vld) begin
            if (pkt_sop) begin
              key_q <= flow_key;
              state <= LOOKUP;
            end else begin
              proto_err <= 1'b1;
            end
          end
        end
        LOOKUP: begin
          stream_id     <= hit ? hit_idx : alloc_ptr;
          new_stream_id <= !hit;
          load_state    <= 1'b1;
          state         <= LOAD;
        end
        LOAD: begin
          state <= GAP;
        end
        GAP: begin
          byte_idx   <= '0;
          first_word <= 1'b1;
          state      <= BYTES;
        end
        BYTES: begin
          if (pkt_vld) begin
            char_in     <= cur_byte;
            char_in_vld <= 1'b1;
            // sop on any word but the first is a framing error; data still flows.
            if ((byte_idx == 2'd0) && pkt_sop && !first_word) begin
              proto_err <= 1'b1;
            end
            if (byte_idx == last_idx) begin
              byte_idx   <= '0;
              first_word <= 1'b0;
              if (pkt_eop) begin
                drain_cnt <= DRAIN_W'(EOP_DRAIN - 1);
                state     <= DRAIN;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        DRAIN: begin
          // First DRAIN cycle is the one the last byte is visible in.
          if (drain_cnt == '0) begin
            eop   <= 1'b1;
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
